// File: rtl/logic_sweep_tester_pkg.sv
// Shared types and constants for the exhaustive 5-input sweep tester.
package logic_sweep_tester_pkg;

  localparam int VEC_W   = 5;
  localparam int NUM_VEC = 32;
  localparam int NUM_F   = 4;

  // Vector bit positions: A is the MSB of the driven vector
  localparam int BIT_A = 4;
  localparam int BIT_B = 3;
  localparam int BIT_C = 2;
  localparam int BIT_D = 1;
  localparam int BIT_E = 0;

  localparam int BIT_F1 = 0;
  localparam int BIT_F2 = 1;
  localparam int BIT_F3 = 2;
  localparam int BIT_F4 = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/logic_sweep_tester_if.sv
// Control, stimulus and capture bundle between the sweep tester and its user.
interface logic_sweep_tester_if;
  import logic_sweep_tester_pkg::*;

  logic               start_i;
  logic               hold_i;
  logic [NUM_F-1:0]   f_i;
  logic [VEC_W-1:0]   vec_o;
  logic               busy_o;
  logic               done_o;
  logic [NUM_VEC-1:0] f1_map_o;
  logic [NUM_VEC-1:0] f2_map_o;
  logic [NUM_VEC-1:0] f3_map_o;
  logic [NUM_VEC-1:0] f4_map_o;
  logic               mismatch_o;
  logic [VEC_W-1:0]   mismatch_idx_o;

  modport slave (
    input  start_i, hold_i, f_i,
    output vec_o, busy_o, done_o, f1_map_o, f2_map_o, f3_map_o, f4_map_o,
           mismatch_o, mismatch_idx_o
  );

  modport master (
    output start_i, hold_i, f_i,
    input  vec_o, busy_o, done_o, f1_map_o, f2_map_o, f3_map_o, f4_map_o,
           mismatch_o, mismatch_idx_o
  );
endinterface

// File: rtl/logic_sweep_tester_sweep_capture.sv
// One output's minterm map: writes the sampled bit at the current vector and
// flags a disagreement with the expected map when checking is enabled.
module sweep_capture
  import logic_sweep_tester_pkg::*;
#(
  parameter logic [NUM_VEC-1:0] EXP = '0,
  parameter bit                 EN  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               wr_en_i,
  input  logic [VEC_W-1:0]   idx_i,
  input  logic               bit_i,
  output logic [NUM_VEC-1:0] map_o,
  output logic               mis_o
);

  logic [NUM_VEC-1:0] map_q, map_d;

  always_comb begin
    map_d = map_q;
    if (clr_i)        map_d = '0;
    else if (wr_en_i) map_d[idx_i] = bit_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) map_q <= '0;
    else     map_q <= map_d;
  end

  assign map_o = map_q;
  assign mis_o = wr_en_i && EN && (bit_i != EXP[idx_i]);

endmodule

// File: rtl/logic_sweep_tester.sv
// Steps all 32 input vectors through the block under test, holding each for
// SETTLE+1 cycles, and captures one truth-table map per output.
module logic_sweep_tester
  import logic_sweep_tester_pkg::*;
#(
  parameter int          SETTLE     = 2,
  parameter logic [31:0] EXP_F1     = 32'h0000_0000,
  parameter logic [31:0] EXP_F2     = 32'h0000_0000,
  parameter logic [31:0] EXP_F3     = 32'h0000_0000,
  parameter logic [31:0] EXP_F4     = 32'h0000_0000,
  parameter logic [3:0]  CHECK_MASK = 4'b0000
) (
  input logic                 clk,
  input logic                 rst,
  logic_sweep_tester_if.slave bus
);

  localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  // With no settle window the FSM samples every cycle and never visits SETTLE
  localparam state_e AFTER_VEC = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
  localparam logic [NUM_F*NUM_VEC-1:0] EXP_ALL = {EXP_F4, EXP_F3, EXP_F2, EXP_F1};

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               mis_q, mis_d;
  logic [VEC_W-1:0]   idx_q, idx_d;
  logic               clr;
  logic               wr_en;
  logic [NUM_F-1:0]   mis_vec;
  logic [NUM_VEC-1:0] maps [NUM_F];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    clr     = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          clr     = 1'b1;
          vec_d   = '0;
          cnt_d   = '0;
          state_d = AFTER_VEC;
        end
      end
      ST_SETTLE: begin
        if (!bus.hold_i) begin
          if (cnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
          else                      cnt_d   = cnt_q + 4'd1;
        end
      end
      ST_SAMPLE: begin
        if (!bus.hold_i) begin
          wr_en = 1'b1;
          cnt_d = '0;
          if (vec_q == VEC_W'(NUM_VEC - 1)) begin
            state_d = ST_FINISH;
          end else begin
            vec_d   = vec_q + 5'd1;
            state_d = AFTER_VEC;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Only the first failing vector of a sweep is recorded
  always_comb begin
    mis_d = mis_q;
    idx_d = idx_q;
    if (clr) begin
      mis_d = 1'b0;
      idx_d = '0;
    end else if (wr_en && (|mis_vec) && !mis_q) begin
      mis_d = 1'b1;
      idx_d = vec_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q <= '0;
      cnt_q <= '0;
      mis_q <= 1'b0;
      idx_q <= '0;
    end else begin
      vec_q <= vec_d;
      cnt_q <= cnt_d;
      mis_q <= mis_d;
      idx_q <= idx_d;
    end
  end

  for (genvar k = 0; k < NUM_F; k++) begin : g_cap
    sweep_capture #(
      .EXP (EXP_ALL[k*NUM_VEC +: NUM_VEC]),
      .EN  (CHECK_MASK[k])
    ) u_cap (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (clr),
      .wr_en_i (wr_en),
      .idx_i   (vec_q),
      .bit_i   (bus.f_i[k]),
      .map_o   (maps[k]),
      .mis_o   (mis_vec[k])
    );
  end

  assign bus.vec_o          = vec_q;
  assign bus.busy_o         = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign bus.done_o         = (state_q == ST_FINISH);
  assign bus.f1_map_o       = maps[BIT_F1];
  assign bus.f2_map_o       = maps[BIT_F2];
  assign bus.f3_map_o       = maps[BIT_F3];
  assign bus.f4_map_o       = maps[BIT_F4];
  assign bus.mismatch_o     = mis_q;
  assign bus.mismatch_idx_o = idx_q;

endmodule

// File: tb/tb_logic_sweep_tester.sv
// Scoreboard bench: three tester instances with different settle/check setups
// driving a modelled 5-input block; a monitor per instance checks each done.
module tb_logic_sweep_tester;

  typedef struct {
    logic [31:0] m1, m2, m3, m4;
    logic        mis;
    logic [4:0]  idx;
    int          done_cyc;
    int          busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   bc [3];
  exp_t sq [3][$];

  logic [2:0] start_v;
  logic [2:0] hold_v;
  wire  [2:0] done_v;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic_sweep_tester_if bus0 ();
  logic_sweep_tester_if bus1 ();
  logic_sweep_tester_if bus2 ();

  // Block under test: F1=A(CD+B)+BC'D', F2=E, F3=A, F4=BE'
  function automatic logic [3:0] fmodel(input logic [4:0] v);
    logic a, b, c, d, e, f1;
    {a, b, c, d, e} = v;
    f1 = (a & ((c & d) | b)) | (b & ~c & ~d);
    return {b & ~e, a, e, f1};
  endfunction

  assign bus0.start_i = start_v[0];
  assign bus1.start_i = start_v[1];
  assign bus2.start_i = start_v[2];
  assign bus0.hold_i  = hold_v[0];
  assign bus1.hold_i  = hold_v[1];
  assign bus2.hold_i  = hold_v[2];
  assign bus0.f_i     = fmodel(bus0.vec_o);
  assign bus1.f_i     = fmodel(bus1.vec_o);
  assign bus2.f_i     = 4'hF;
  assign done_v       = {bus2.done_o, bus1.done_o, bus0.done_o};

  logic_sweep_tester #(
    .SETTLE(2), .EXP_F1(32'hFFC0_0300), .CHECK_MASK(4'b0001)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  logic_sweep_tester #(
    .SETTLE(2), .EXP_F1(32'hFFC0_0200), .EXP_F2(32'hAAAA_AAAA),
    .EXP_F3(32'hFFEF_0000), .CHECK_MASK(4'b0111)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic_sweep_tester #(
    .SETTLE(0), .EXP_F1(32'hFFFF_FFFF), .EXP_F2(32'hFFFF_FFFF),
    .EXP_F3(32'hFFFF_FFFF), .EXP_F4(32'hFFFF_FFFF), .CHECK_MASK(4'b1111)
  ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic mon(input int k, input logic done, input logic busy,
                     input logic [31:0] m1, input logic [31:0] m2,
                     input logic [31:0] m3, input logic [31:0] m4,
                     input logic mis, input logic [4:0] idx);
    exp_t  e;
    string t;
    t = $sformatf("dut%0d", k);
    if (rst) begin
      bc[k] = 0;
      return;
    end
    if (busy) bc[k]++;
    if (done) begin
      if (sq[k].size() == 0) begin
        chk({t, "_spurious_done"}, 32'(done), 32'd0);
      end else begin
        e = sq[k].pop_front();
        chk({t, "_f1_map"}, m1, e.m1);
        chk({t, "_f2_map"}, m2, e.m2);
        chk({t, "_f3_map"}, m3, e.m3);
        chk({t, "_f4_map"}, m4, e.m4);
        chk({t, "_mismatch"}, 32'(mis), 32'(e.mis));
        chk({t, "_mismatch_idx"}, 32'(idx), 32'(e.idx));
        chk({t, "_done_cycle"}, cyc, e.done_cyc);
        chk({t, "_busy_cycles"}, bc[k], e.busy);
      end
      bc[k] = 0;
    end
  endtask

  always @(negedge clk) mon(0, bus0.done_o, bus0.busy_o, bus0.f1_map_o, bus0.f2_map_o,
                            bus0.f3_map_o, bus0.f4_map_o, bus0.mismatch_o, bus0.mismatch_idx_o);
  always @(negedge clk) mon(1, bus1.done_o, bus1.busy_o, bus1.f1_map_o, bus1.f2_map_o,
                            bus1.f3_map_o, bus1.f4_map_o, bus1.mismatch_o, bus1.mismatch_idx_o);
  always @(negedge clk) mon(2, bus2.done_o, bus2.busy_o, bus2.f1_map_o, bus2.f2_map_o,
                            bus2.f3_map_o, bus2.f4_map_o, bus2.mismatch_o, bus2.mismatch_idx_o);

  // Pushes the expected result, then pulses start for one accepting edge
  task automatic go(input int k, input int lat, input exp_t e);
    @(negedge clk);
    e.done_cyc = cyc + 1 + lat;
    e.busy     = lat;
    sq[k].push_back(e);
    start_v[k] = 1'b1;
    @(posedge clk);
    #1 start_v[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done_v[k]) return;
    end
    chk($sformatf("dut%0d_done_timeout", k), 32'(done_v[k]), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e0, e1, e2;
    int   acc;
    e0.m1 = 32'hFFC0_0300; e0.m2 = 32'hAAAA_AAAA; e0.m3 = 32'hFFFF_0000; e0.m4 = 32'h5500_5500;
    e0.mis = 1'b0; e0.idx = 5'd0; e0.done_cyc = 0; e0.busy = 0;
    e1 = e0; e1.mis = 1'b1; e1.idx = 5'd8;
    e2 = e0; e2.m1 = '1; e2.m2 = '1; e2.m3 = '1; e2.m4 = '1;

    rst = 1'b1; start_v = '0; hold_v = '0;
    repeat (2) @(negedge clk);
    chk("rst_vec", 32'(bus0.vec_o), 32'd0);
    chk("rst_busy", 32'(bus0.busy_o), 32'd0);
    chk("rst_done", 32'(bus0.done_o), 32'd0);
    chk("rst_f1_map", bus0.f1_map_o, 32'd0);
    chk("rst_mismatch", 32'(bus2.mismatch_o), 32'd0);
    chk("rst_mismatch_idx", 32'(bus2.mismatch_idx_o), 32'd0);
    #1 rst = 1'b0;

    // Settle of 2, F1 checked and matching
    go(0, 96, e0);
    wait_done(0, 200);

    // First mismatch at vector 8 (F1); F3 also fails later at vector 20
    go(1, 96, e1);
    wait_done(1, 200);
    repeat (3) @(negedge clk);
    chk("dut1_keep_f1_map", bus1.f1_map_o, 32'hFFC0_0300);
    chk("dut1_keep_mismatch", 32'(bus1.mismatch_o), 32'd1);
    chk("dut1_keep_idx", 32'(bus1.mismatch_idx_o), 32'd8);

    // No settle window: one vector per cycle
    go(2, 32, e2);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk($sformatf("dut2_vec_step%0d", i), 32'(bus2.vec_o), i);
    end
    wait_done(2, 10);

    // Hold across the final sample edge, stray start mid-sweep
    go(0, 101, e0);
    acc = cyc;
    repeat (40) @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    while (cyc < acc + 95) @(negedge clk);
    chk("hold_vec_at_31", 32'(bus0.vec_o), 32'd31);
    hold_v[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold_no_done%0d", i), 32'(bus0.done_o), 32'd0);
      chk($sformatf("hold_no_write%0d", i), 32'(bus0.f1_map_o[31]), 32'd0);
    end
    hold_v[0] = 1'b0;
    wait_done(0, 10);

    // Asynchronous reset mid-sweep, then a clean full sweep
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus0.vec_o == 5'd17) break;
    end
    chk("midreset_reached_17", 32'(bus0.vec_o), 32'd17);
    #3 rst = 1'b1;
    #1;
    chk("midreset_vec", 32'(bus0.vec_o), 32'd0);
    chk("midreset_busy", 32'(bus0.busy_o), 32'd0);
    chk("midreset_done", 32'(bus0.done_o), 32'd0);
    chk("midreset_f1_map", bus0.f1_map_o, 32'd0);
    chk("midreset_f2_map", bus0.f2_map_o, 32'd0);
    chk("midreset_mismatch", 32'(bus0.mismatch_o), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    go(0, 96, e0);
    wait_done(0, 200);

    repeat (3) @(negedge clk);
    chk("sb_empty0", sq[0].size(), 32'd0);
    chk("sb_empty1", sq[1].size(), 32'd0);
    chk("sb_empty2", sq[2].size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
